mm_seq_ctrl: RTL
================

Name: mm_seq_ctrl

Overview:
Top-level sequencer for the 4-MAC matrix-multiply datapath. It computes a 4xNCOL result one output column at a time. For each column it:
- clears the four MAC accumulators,
- streams K input/coefficient address pairs into them,
- drains the read and accumulate pipeline,
- pulses web to the writeback unit,
- waits out the writeback window.

It sits between the host start/done handshake and the RAM, coefficient ROM, MAC units and writeback unit.

Parameters:
K, 8, accumulation length (products per result); >=2
NCOL, 4, output columns per job
RD_LAT, 1, cycles from mem_rd_en/address to data valid at MAC inputs
WB_CYCLES, 4, cycles the writeback unit stays busy after the web pulse
ADDR_W, 5, input RAM address width; must hold NCOL*K-1
CADDR_W, 3, coefficient address width; must hold K-1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
start  in  1  job request; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted through the DONE cycle
done  out  1  one-cycle pulse when the job completes
mem_rd_en  out  1  input RAM read enable
mem_addr  out  ADDR_W  input RAM read address = col*K + k
coef_addr  out  CADDR_W  coefficient ROM address = k
mac_clr  out  1  one-cycle accumulator clear, all 4 MACs
mac_en  out  1  MAC accumulate enable, aligned with valid data
web  out  1  one-cycle writeback start pulse

Behaviour:
- Reset (async, rst=0): state=IDLE; col=0, k=0; RD_LAT delay line cleared. All outputs are 0, including mem_addr and coef_addr. Reset mid-job abandons the job immediately, and no further web pulse occurs.
- All outputs are registered or decoded from the registered state; there are no combinational paths from start.
- States: IDLE, CLEAR, ACC, DRAIN, WB, WB_WAIT, DONE.
- IDLE: busy=0. If start=1, go to CLEAR with col=0. Otherwise stay.
- CLEAR (1 cycle): mac_clr=1, k=0; go to ACC.
- ACC (exactly K cycles):
  - mem_rd_en=1, mem_addr=col*K+k, coef_addr=k.
  - k increments each cycle.
  - Go to DRAIN after the cycle with k=K-1.
- mac_en: mem_rd_en delayed by RD_LAT cycles through a shift register. It is high for exactly K consecutive cycles per column and never overlaps mac_clr.
- DRAIN (RD_LAT+1 cycles): covers the data-valid delay plus the accumulator register, so all 4 MAC outputs are final on the cycle web is asserted.
- WB (1 cycle): web=1.
- WB_WAIT (WB_CYCLES cycles): web=0, no RAM reads.
  - Exit when col=NCOL-1: go to DONE.
  - Otherwise: col+1, go to CLEAR.
- DONE (1 cycle): done=1, busy=1; go to IDLE. start is first sampled again in the following IDLE cycle.
- start while not in IDLE is ignored; there is no queueing. A held-high start begins a new job on every IDLE cycle.
- Per-column period P = 1 + K + (RD_LAT+1) + 1 + WB_CYCLES, which is 16 with defaults. Job length is NCOL*P + 1 cycles after the start-sample edge.
- mem_addr never exceeds NCOL*K-1. col and k do not wrap within a job.
- Widths: col is ceil(log2(NCOL)) bits; k is CADDR_W bits. mem_addr is computed as col*K+k at ADDR_W bits, with no overflow given the parameter constraints.

Test Plan:
- Reset then idle: rst low mid-sim, start=0 -> all outputs 0, busy=0, no pulses for 20 cycles.
- Single job, defaults: start pulse sampled at edge 0 ->
  - mac_clr in cycles 1,17,33,49;
  - mem_rd_en in cycles 2-9 with mem_addr 0..7 (col0), then 8..15, 16..23, 24..31;
  - mac_en in cycles 3-10 (col0);
  - web in cycles 12,28,44,60;
  - done in cycle 65 only;
  - busy in cycles 1-65.
- start held high during a job -> no restart or glitch before done. A new job begins, with mac_clr in cycle 67.
- Reset mid-job: rst=0 in cycle 30 -> outputs 0 asynchronously. After release, no web, and idle until the next start.
- Parameter sweep K=4, NCOL=2, RD_LAT=2 -> P=13 and done in cycle 27. mac_en is high for exactly 4 cycles per column. mem_addr covers 0..7.
- Golden model: connect the real writeback and MAC units with random 4x8 and 8x4 matrices -> RAM addresses 0..15 match the reference product (column-major, 4 per column).

Source files
------------

// File: rtl/mm_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the matrix-multiply sequencer
// and its host, RAM/ROM address ports, MAC units and writeback unit.
interface mm_seq_if #(
    parameter int ADDR_W  = 5,
    parameter int CADDR_W = 3
);
    logic               start;
    logic               busy;
    logic               done;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [CADDR_W-1:0] coef_addr;
    logic               mac_clr;
    logic               mac_en;
    logic               web;

    modport master (
        input  start,
        output busy, done, mem_rd_en, mem_addr, coef_addr, mac_clr, mac_en, web
    );

    modport slave (
        output start,
        input  busy, done, mem_rd_en, mem_addr, coef_addr, mac_clr, mac_en, web
    );
endinterface

// File: rtl/mm_seq_ctrl.sv
// Column-at-a-time sequencer for the 4-MAC matrix multiply: clear, accumulate K
// products, drain the read/accumulate pipeline, pulse writeback, wait it out.
module mm_seq_ctrl #(
    parameter int K         = 8,
    parameter int NCOL      = 4,
    parameter int RD_LAT    = 1,
    parameter int WB_CYCLES = 4,
    parameter int ADDR_W    = 5,
    parameter int CADDR_W   = 3
) (
    input  logic     clk,
    input  logic     rst,
    mm_seq_if.master bus
);
    localparam int COL_W   = (NCOL > 1) ? $clog2(NCOL) : 1;
    localparam int CNT_MAX = (RD_LAT + 1 > WB_CYCLES) ? RD_LAT + 1 : WB_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ACC     = 3'd2,
        DRAIN   = 3'd3,
        WB      = 3'd4,
        WB_WAIT = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t             state, state_n;
    logic [COL_W-1:0]   col, col_n;
    logic [CADDR_W-1:0] k, k_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [RD_LAT-1:0]  vld_p;
    logic               rd_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            col   <= '0;
            k     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            col   <= col_n;
            k     <= k_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = col;
        k_n     = k;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = CLEAR;
                    col_n   = '0;
                end
            end
            CLEAR: begin
                k_n     = '0;
                state_n = ACC;
            end
            ACC: begin
                // k parks at K-1 on the last read so it never wraps
                if (k == CADDR_W'(K - 1)) begin
                    state_n = DRAIN;
                    cnt_n   = '0;
                end else begin
                    k_n = k + CADDR_W'(1);
                end
            end
            DRAIN: begin
                if (cnt == CNT_W'(RD_LAT)) state_n = WB;
                else                       cnt_n   = cnt + CNT_W'(1);
            end
            WB: begin
                state_n = WB_WAIT;
                cnt_n   = '0;
            end
            WB_WAIT: begin
                if (cnt == CNT_W'(WB_CYCLES - 1)) begin
                    if (col == COL_W'(NCOL - 1)) begin
                        state_n = DONE;
                    end else begin
                        col_n   = col + COL_W'(1);
                        state_n = CLEAR;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign rd_en = (state == ACC);

    // read-valid stage boundary: mac_en is the read strobe delayed by RD_LAT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_p <= '0;
        else      vld_p <= RD_LAT'({vld_p, rd_en});
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.mac_clr   = (state == CLEAR);
    assign bus.web       = (state == WB);
    assign bus.mem_rd_en = rd_en;
    assign bus.mac_en    = vld_p[RD_LAT-1];
    assign bus.mem_addr  = rd_en ? (ADDR_W'(col) * ADDR_W'(K) + ADDR_W'(k)) : '0;
    assign bus.coef_addr = rd_en ? k : '0;
endmodule
